// File: rtl/pipelined_variable_circular_rotator_pkg.sv
// Shared constants for the variable circular rotator.
// Latency: none (package only).
// Backpressure: not applicable.
package pipelined_variable_circular_rotator_pkg;

    // Direction encoding carried alongside each operand.
    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;

    // Width check used at elaboration: the barrel structure needs N = 2^W.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipelined_variable_circular_rotator_rotator_stage.sv
// One barrel step: rotate by 2^K when amount bit K is set, then register the result.
// Latency: 1 cycle from input to out_* when the slot is free.
// Backpressure: slot holds while full and ready_in is low; an empty slot always loads.
module rotator_stage
    import pipelined_variable_circular_rotator_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [N-1:0]         in_dat,
    input  logic [$clog2(N)-1:0] in_amt,
    input  logic                 in_dir,
    input  logic                 ready_in,
    output logic                 ready_out,
    output logic                 out_vld,
    output logic [N-1:0]         out_dat,
    output logic [$clog2(N)-1:0] out_amt,
    output logic                 out_dir
);

    localparam int S = 1 << K;

    logic [N-1:0] rot_l;
    logic [N-1:0] rot_r;
    logic [N-1:0] rot_dat;

    // Fixed rotations by S; both are pure wiring.
    assign rot_l = {in_dat[N-1-S:0], in_dat[N-1:N-S]};
    assign rot_r = {in_dat[S-1:0], in_dat[N-1:S]};

    // Apply this stage's power-of-two step only when its amount bit is set.
    always_comb begin
        rot_dat = in_dat;
        if (in_amt[K]) begin
            rot_dat = (in_dir == ROT_LEFT) ? rot_l : rot_r;
        end
    end

    // The slot can take new content when it is empty or its content moves on now.
    assign ready_out = !out_vld || ready_in;

    // Slot register: valid follows upstream on every load, payload is captured
    // only for real operands so bubbles do not toggle the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_amt <= '0;
            out_dir <= ROT_LEFT;
        end else if (ready_out) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= rot_dat;
                out_amt <= in_amt;
                out_dir <= in_dir;
            end
        end
    end

endmodule

// File: rtl/pipelined_variable_circular_rotator.sv
// Variable-amount circular rotator, log2(N) registered barrel stages.
// Latency: W = log2(N) cycles from input transfer to res_vld when unstalled.
// Backpressure: valid/ready both sides; bubbles collapse, full pipe holds with res stable.
module pipelined_variable_circular_rotator
    import pipelined_variable_circular_rotator_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_vld,
    output logic                 arg_rdy,
    input  logic [N-1:0]         a,
    input  logic [$clog2(N)-1:0] amt,
    input  logic                 dir,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [N-1:0]         res
);

    localparam int W = $clog2(N);

    if (N < 2 || !is_pow2(N)) begin : g_bad_width
        $error("pipelined_variable_circular_rotator: N must be a power of two and at least 2");
    end

    // Index k is the input of stage k; index k+1 is the register that stage writes.
    logic [W:0]         vld_c;
    logic [W:0][N-1:0]  dat_c;
    logic [W:0][W-1:0]  amt_c;
    logic [W:0]         dir_c;
    // rdy_c[k] is the ready seen by stage k-1's downstream side (ready of register k).
    logic [W:1]         rdy_c;
    logic [W-1:0]       slot_rdy;
    logic               unused_tail;

    assign vld_c[0] = arg_vld;
    assign dat_c[0] = a;
    assign amt_c[0] = amt;
    assign dir_c[0] = dir;

    // Ready chain from the output back toward the input; depends only on the
    // registered valids and res_rdy, so arg_vld never reaches arg_rdy.
    always_comb begin
        rdy_c    = '0;
        rdy_c[W] = res_rdy;
        for (int k = W - 1; k >= 1; k--) begin
            rdy_c[k] = !vld_c[k+1] || rdy_c[k+1];
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_stage
        rotator_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_vld    (vld_c[k]),
            .in_dat    (dat_c[k]),
            .in_amt    (amt_c[k]),
            .in_dir    (dir_c[k]),
            .ready_in  (rdy_c[k+1]),
            .ready_out (slot_rdy[k]),
            .out_vld   (vld_c[k+1]),
            .out_dat   (dat_c[k+1]),
            .out_amt   (amt_c[k+1]),
            .out_dir   (dir_c[k+1])
        );
    end

    assign arg_rdy = slot_rdy[0];
    assign res_vld = vld_c[W];
    assign res     = dat_c[W];

    // The last register's amount/direction and the inner slot readies have no consumer.
    assign unused_tail = ^{amt_c[W], dir_c[W], slot_rdy};

endmodule

// File: tb/tb_pipelined_variable_circular_rotator.sv
module tb_pipelined_variable_circular_rotator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // N = 8 instance
    logic       arg_vld, arg_rdy, dir, res_vld, res_rdy;
    logic [7:0] a, res;
    logic [2:0] amt;

    // N = 2 instance
    logic       arg_vld2, arg_rdy2, dir2, res_vld2;
    logic [1:0] a2, res2;
    logic [0:0] amt2;

    // N = 32 instance
    logic        arg_vld32, arg_rdy32, dir32, res_vld32;
    logic [31:0] a32, res32;
    logic [4:0]  amt32;

    pipelined_variable_circular_rotator #(.N(8)) dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .amt(amt),
        .dir(dir), .res_vld(res_vld), .res_rdy(res_rdy), .res(res)
    );

    pipelined_variable_circular_rotator #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld2), .arg_rdy(arg_rdy2), .a(a2), .amt(amt2),
        .dir(dir2), .res_vld(res_vld2), .res_rdy(1'b1), .res(res2)
    );

    pipelined_variable_circular_rotator #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld32), .arg_rdy(arg_rdy32), .a(a32), .amt(amt32),
        .dir(dir32), .res_vld(res_vld32), .res_rdy(1'b1), .res(res32)
    );

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        logic       dir;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    logic [7:0] bp_a   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] bp_amt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic       bp_dir [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int out_cnt  = 0;
    logic in_x, out_x;
    logic [7:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rotation, bit by bit.
    function automatic logic [31:0] rot_model(input logic [31:0] x, input int s, input logic d,
                                              input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (d == 1'b0) r[(i + s) % n] = x[i];
            else           r[i] = x[(i + s) % n];
        end
        return r;
    endfunction

    // One clock of the N=8 instance with scoreboard bookkeeping.
    task automatic tick();
        logic       hold_pend;
        logic [7:0] hold_val;
        logic [7:0] e;
        #1;
        in_x      = arg_vld && arg_rdy;
        out_x     = res_vld && res_rdy;
        hold_pend = res_vld && !res_rdy;
        hold_val  = res;
        if (out_x) begin
            out_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra: got res=0x%0h while no result was expected", res);
            end else begin
                e = q.pop_front();
                chk("sb_order", {24'd0, res}, {24'd0, e});
            end
        end
        if (in_x) q.push_back(8'(rot_model({24'd0, a}, int'(amt), dir, 8)));
        @(posedge clk);
        #1;
        if (rst) q.delete();
        else if (hold_pend) chk("stall_hold", {23'd0, res_vld, res}, {23'd0, 1'b1, hold_val});
        cyc++;
    endtask

    task automatic drain();
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        repeat (6) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic run32(input logic [31:0] av, input logic [4:0] s, input logic d,
                         input logic [31:0] exp);
        int lat = 0;
        a32 = av; amt32 = s; dir32 = d; arg_vld32 = 1'b1;
        #1;
        chk("n32_arg_rdy", {31'd0, arg_rdy32}, 1);
        @(posedge clk); #1;
        arg_vld32 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (res_vld32) begin lat = c; break; end
            @(posedge clk); #1;
        end
        chk("n32_latency", lat, 5);
        chk("n32_res", res32, exp);
        @(posedge clk); #1;
    endtask

    task automatic run2(input logic [1:0] av, input logic s, input logic d, input logic [1:0] exp);
        int lat = 0;
        a2 = av; amt2 = s; dir2 = d; arg_vld2 = 1'b1;
        #1;
        chk("n2_arg_rdy", {31'd0, arg_rdy2}, 1);
        @(posedge clk); #1;
        arg_vld2 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (res_vld2) begin lat = c; break; end
            @(posedge clk); #1;
        end
        chk("n2_latency", lat, 1);
        chk("n2_res", {30'd0, res2}, {30'd0, exp});
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int lat, k, stalls, n0, nin, j, ghost;
        logic [7:0] hold;

        vecs[0] = '{8'hB1, 3'd3, 1'b0, 8'h8D};
        vecs[1] = '{8'hB1, 3'd3, 1'b1, 8'h36};
        vecs[2] = '{8'hA5, 3'd0, 1'b0, 8'hA5};
        vecs[3] = '{8'hA5, 3'd0, 1'b1, 8'hA5};
        vecs[4] = '{8'h81, 3'd1, 1'b0, 8'h03};
        vecs[5] = '{8'h81, 3'd1, 1'b1, 8'hC0};
        vecs[6] = '{8'hF0, 3'd4, 1'b0, 8'h0F};
        vecs[7] = '{8'h01, 3'd7, 1'b1, 8'h02};
        vecs[8] = '{8'h80, 3'd7, 1'b0, 8'h40};
        vecs[9] = '{8'h3C, 3'd2, 1'b1, 8'h0F};

        rst = 1'b1;
        arg_vld = 1'b0; a = '0; amt = '0; dir = 1'b0; res_rdy = 1'b0;
        arg_vld2 = 1'b0; a2 = '0; amt2 = '0; dir2 = 1'b0;
        arg_vld32 = 1'b0; a32 = '0; amt32 = '0; dir32 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_res_vld", {31'd0, res_vld}, 0);
        chk("rst_res", {24'd0, res}, 0);
        chk("rst_arg_rdy", {31'd0, arg_rdy}, 1);
        chk("rst_n2_res_vld", {31'd0, res_vld2}, 0);
        chk("rst_n32_res_vld", {31'd0, res_vld32}, 0);

        // Directed vectors, one operand at a time through an empty pipe.
        res_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; amt = vecs[i].amt; dir = vecs[i].dir; arg_vld = 1'b1;
            tick();
            chk("vec_accept", {31'd0, in_x}, 1);
            arg_vld = 1'b0;
            lat = 0;
            for (int c = 1; c <= 8; c++) begin
                if (res_vld) begin lat = c; break; end
                tick();
            end
            chk("vec_latency", lat, 3);
            chk($sformatf("vec%0d_res", i), {24'd0, res}, {24'd0, vecs[i].exp});
            tick();
        end

        // Back-to-back amount sweep: results must arrive in consecutive cycles.
        k = 0;
        for (int c = 0; c < 14; c++) begin
            arg_vld = (c < 8); a = 8'h01; amt = 3'(c); dir = 1'b0;
            if (res_vld) begin
                chk("sweep_res", {24'd0, res}, 32'(1 << k));
                chk("sweep_slot", c, 3 + k);
                k++;
            end
            tick();
        end
        chk("sweep_count", k, 8);
        drain();

        // Continuous random stream with no backpressure.
        stalls = 0;
        n0 = out_cnt;
        for (int i = 0; i < 200; i++) begin
            arg_vld = 1'b1; a = 8'($urandom); amt = 3'($urandom_range(0, 7));
            dir = 1'($urandom_range(0, 1));
            tick();
            if (!in_x) stalls++;
        end
        drain();
        chk("stream_stalls", stalls, 0);
        chk("stream_count", out_cnt - n0, 200);

        // Random handshakes on both sides.
        n0 = out_cnt;
        nin = 0;
        for (int i = 0; i < 300; i++) begin
            arg_vld = 1'($urandom_range(0, 1));
            res_rdy = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); amt = 3'($urandom_range(0, 7)); dir = 1'($urandom_range(0, 1));
            tick();
            if (in_x) nin++;
        end
        drain();
        chk("random_count", out_cnt - n0, nin);

        // Backpressure: the pipe fills with three operands and then stalls.
        res_rdy = 1'b0;
        j = 0;
        hold = '0;
        for (int c = 0; c < 8; c++) begin
            arg_vld = (j < 5);
            if (j < 5) begin a = bp_a[j]; amt = bp_amt[j]; dir = bp_dir[j]; end
            tick();
            if (in_x) j++;
            if (c == 4) hold = res;
        end
        chk("bp_accepted", j, 3);
        chk("bp_arg_rdy", {31'd0, arg_rdy}, 0);
        chk("bp_res_vld", {31'd0, res_vld}, 1);
        chk("bp_res_stable", {24'd0, res}, {24'd0, hold});
        chk("bp_head", {24'd0, res}, rot_model({24'd0, bp_a[0]}, int'(bp_amt[0]), bp_dir[0], 8));
        res_rdy = 1'b1;
        #1;
        chk("full_accept_rdy", {31'd0, arg_rdy}, 1);
        n0 = out_cnt;
        for (int c = 0; c < 20; c++) begin
            arg_vld = (j < 5);
            if (j < 5) begin a = bp_a[j]; amt = bp_amt[j]; dir = bp_dir[j]; end
            tick();
            if (in_x) j++;
        end
        chk("bp_all_accepted", j, 5);
        chk("bp_out_count", out_cnt - n0, 5);
        chk("bp_sb_empty", q.size(), 0);

        // Reset with two operands in flight: neither may emerge.
        res_rdy = 1'b1;
        arg_vld = 1'b1; a = 8'h0F; amt = 3'd1; dir = 1'b0;
        tick();
        a = 8'hF0; amt = 3'd2; dir = 1'b1;
        tick();
        arg_vld = 1'b0;
        rst = 1'b1;
        tick();
        chk("rstmid_res_vld", {31'd0, res_vld}, 0);
        chk("rstmid_res", {24'd0, res}, 0);
        rst = 1'b0;
        #1;
        chk("rstmid_arg_rdy", {31'd0, arg_rdy}, 1);
        ghost = 0;
        repeat (6) begin
            if (res_vld) ghost++;
            tick();
        end
        chk("rstmid_ghosts", ghost, 0);

        // Width extremes: single stage and five stages.
        run2(2'b01, 1'b1, 1'b0, 2'b10);
        run2(2'b01, 1'b1, 1'b1, 2'b10);
        run2(2'b10, 1'b0, 1'b1, 2'b10);
        run32(32'h8000_0001, 5'd31, 1'b1, 32'h0000_0003);
        run32(32'h1234_5678, 5'd4, 1'b0, 32'h2345_6781);
        run32(32'h1234_5678, 5'd16, 1'b1, 32'h5678_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
